// File: rtl/el2_dccm_store_buf.sv
// rtl/el2_dccm_store_buf.sv - DCCM store buffer with in-order RMW drain and load forwarding
module el2_dccm_store_buf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [31:0]       st_data_i,
  input  logic [3:0]        st_byteen_i,
  input  logic              ld_rden_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic [3:0]        fwd_byteen_o,
  output logic [31:0]       fwd_data_o,
  output logic              dccm_rden_o,
  output logic [ADDR_W-1:0] dccm_rd_addr_o,
  input  logic [31:0]       dccm_rd_data_i,
  output logic              dccm_wren_o,
  output logic [ADDR_W-1:0] dccm_wr_addr_o,
  output logic [31:0]       dccm_wr_data_o,
  output logic              sb_empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    MERGE = 2'd2,
    WR    = 2'd3
  } state_e;

  // Entry storage; addresses are kept word aligned
  logic [ADDR_W-1:0] addr_q   [DEPTH];
  logic [31:0]       data_q   [DEPTH];
  logic [3:0]        byteen_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q, state_d;
  logic [31:0]       merged_q, merged_d;

  state_e            eff_state;
  logic              push;
  logic              retire;
  logic              rden;
  logic              wren;

  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;
  logic [3:0]        head_byteen;
  logic              head_full;
  logic [PTR_W-1:0]  next_ptr;
  logic              next_full;

  logic [PTR_W-1:0]  slot_idx [DEPTH];
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{st_addr_i[1:0], ld_addr_i[1:0]};

  assign head_addr   = addr_q[rd_ptr_q];
  assign head_data   = data_q[rd_ptr_q];
  assign head_byteen = byteen_q[rd_ptr_q];
  assign head_full   = (head_byteen == 4'hF);
  assign next_ptr    = rd_ptr_q + PTR_W'(1);
  assign next_full   = (byteen_q[next_ptr] == 4'hF);

  assign st_ready_o  = (count_q < CNT_W'(DEPTH));
  assign push        = st_valid_i && st_ready_o;
  assign sb_empty_o  = (count_q == '0) && (state_q == IDLE);

  assign dccm_rden_o    = rden;
  assign dccm_wren_o    = wren;
  assign dccm_rd_addr_o = head_addr;
  assign dccm_wr_addr_o = head_addr;
  assign dccm_wr_data_o = head_full ? head_data : merged_q;

  // Drain FSM: IDLE with a queued head acts immediately as RD or WR so the
  // first port access happens the cycle after the store is accepted
  always_comb begin
    eff_state = state_q;
    state_d   = state_q;
    merged_d  = merged_q;
    rden      = 1'b0;
    wren      = 1'b0;
    retire    = 1'b0;
    if (state_q == IDLE && count_q != '0) begin
      eff_state = head_full ? WR : RD;
    end
    case (eff_state)
      RD: begin
        if (!ld_rden_i) begin
          rden    = 1'b1;
          state_d = MERGE;
        end else begin
          state_d = RD;
        end
      end
      MERGE: begin
        for (int b = 0; b < 4; b++) begin
          merged_d[8*b +: 8] = head_byteen[b] ? head_data[8*b +: 8]
                                              : dccm_rd_data_i[8*b +: 8];
        end
        state_d = WR;
      end
      WR: begin
        if (!ld_rden_i) begin
          wren   = 1'b1;
          retire = 1'b1;
          if (count_q > CNT_W'(1)) begin
            state_d = next_full ? WR : RD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = WR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push   ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = retire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Buffer slots ordered oldest (0) to youngest
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_idx[i] = rd_ptr_q + PTR_W'(i);
    end
  end

  // Forwarding: walk oldest to youngest so the youngest enabling match wins each lane
  always_comb begin
    fwd_byteen_o = 4'h0;
    fwd_data_o   = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[slot_idx[i]] &&
          (addr_q[slot_idx[i]][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (byteen_q[slot_idx[i]][b]) begin
            fwd_byteen_o[b]     = 1'b1;
            fwd_data_o[8*b +: 8] = data_q[slot_idx[i]][8*b +: 8];
          end
        end
      end
    end
  end

  // State, pointers and entry storage; reset zeroes everything and drops any RMW in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      merged_q <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]   <= '0;
        data_q[i]   <= 32'h0;
        byteen_q[i] <= 4'h0;
      end
    end else begin
      state_q  <= state_d;
      merged_q <= merged_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        addr_q[wr_ptr_q]   <= {st_addr_i[ADDR_W-1:2], 2'b00};
        data_q[wr_ptr_q]   <= st_data_i;
        byteen_q[wr_ptr_q] <= st_byteen_i;
        valid_q[wr_ptr_q]  <= 1'b1;
      end
      if (retire) begin
        valid_q[rd_ptr_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_el2_dccm_store_buf.sv
// tb/tb_el2_dccm_store_buf.sv - self-checking bench for el2_dccm_store_buf
module tb_el2_dccm_store_buf;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [3:0]        st_byteen;
  logic              ld_rden;
  logic [ADDR_W-1:0] ld_addr;
  logic [3:0]        fwd_byteen;
  logic [31:0]       fwd_data;
  logic              dccm_rden;
  logic [ADDR_W-1:0] dccm_rd_addr;
  logic [31:0]       dccm_rd_data;
  logic              dccm_wren;
  logic [ADDR_W-1:0] dccm_wr_addr;
  logic [31:0]       dccm_wr_data;
  logic              sb_empty;

  int n_cmp  = 0;
  int n_fail = 0;
  int viol   = 0;

  logic [31:0] mem_val    = 32'h0;
  logic [31:0] rd_q       = 32'h0;
  logic        inject     = 1'b0;
  logic [31:0] inject_val = 32'h0;

  logic [ADDR_W-1:0] wlog_addr [$];
  logic [31:0]       wlog_data [$];

  typedef struct {
    int                n_st;
    logic [ADDR_W-1:0] ld_addr;
    logic [3:0]        exp_be;
    logic [31:0]       exp_data;
  } fwd_vec_t;

  fwd_vec_t          vecs [8];
  logic [ADDR_W-1:0] s_addr [4];
  logic [31:0]       s_data [4];
  logic [3:0]        s_be   [4];
  logic [31:0]       exp_w  [4];

  always #5 clk = ~clk;

  assign dccm_rd_data = inject ? inject_val : rd_q;

  el2_dccm_store_buf #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .st_valid_i     (st_valid),
    .st_ready_o     (st_ready),
    .st_addr_i      (st_addr),
    .st_data_i      (st_data),
    .st_byteen_i    (st_byteen),
    .ld_rden_i      (ld_rden),
    .ld_addr_i      (ld_addr),
    .fwd_byteen_o   (fwd_byteen),
    .fwd_data_o     (fwd_data),
    .dccm_rden_o    (dccm_rden),
    .dccm_rd_addr_o (dccm_rd_addr),
    .dccm_rd_data_i (dccm_rd_data),
    .dccm_wren_o    (dccm_wren),
    .dccm_wr_addr_o (dccm_wr_addr),
    .dccm_wr_data_o (dccm_wr_data),
    .sb_empty_o     (sb_empty)
  );

  // DCCM model (one-cycle read latency), write log and port-rule monitor
  always @(posedge clk) begin
    rd_q <= dccm_rden ? mem_val : 32'h0;
    if (dccm_wren) begin
      wlog_addr.push_back(dccm_wr_addr);
      wlog_data.push_back(dccm_wr_data);
    end
    if ((dccm_rden || dccm_wren) && ld_rden) viol++;
    if (dccm_rden && dccm_wren) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_st(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_byteen = be;
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int t = 0;
    while (!sb_empty && t < budget) begin
      tick();
      t++;
    end
    chk(nm, {31'd0, sb_empty}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_st_ready"},   {31'd0, st_ready},  32'd1);
    chk({pfx, "_sb_empty"},   {31'd0, sb_empty},  32'd1);
    chk({pfx, "_rden"},       {31'd0, dccm_rden}, 32'd0);
    chk({pfx, "_wren"},       {31'd0, dccm_wren}, 32'd0);
    chk({pfx, "_fwd_be"},     {28'd0, fwd_byteen}, 32'd0);
    chk({pfx, "_fwd_data"},   fwd_data,            32'd0);
    chk({pfx, "_rd_addr"},    {16'd0, dccm_rd_addr}, 32'd0);
    chk({pfx, "_wr_addr"},    {16'd0, dccm_wr_addr}, 32'd0);
    chk({pfx, "_wr_data"},    dccm_wr_data,        32'd0);
  endtask

  initial begin
    int base;
    int pushed;

    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_byteen = '0;
    ld_rden = 1'b0; ld_addr = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst0");

    // Full-word store: write the very next cycle
    tick(); drive_st(16'h0100, 32'hDEADBEEF, 4'hF);
    tick(); st_valid = 1'b0; #1;
    chk("t1_wren",    {31'd0, dccm_wren}, 32'd1);
    chk("t1_wr_addr", {16'd0, dccm_wr_addr}, 32'h0100);
    chk("t1_wr_data", dccm_wr_data, 32'hDEADBEEF);
    chk("t1_no_rden", {31'd0, dccm_rden}, 32'd0);
    tick(); #1;
    chk("t1_empty",   {31'd0, sb_empty}, 32'd1);

    // Partial-word RMW: rden N+1, merge N+2, wren N+3
    mem_val = 32'h11223344;
    tick(); drive_st(16'h0204, 32'h0000AB00, 4'b0010);
    tick(); st_valid = 1'b0; #1;
    chk("t2_rden",    {31'd0, dccm_rden}, 32'd1);
    chk("t2_rd_addr", {16'd0, dccm_rd_addr}, 32'h0204);
    tick(); #1;
    chk("t2_merge_idle_port", {30'd0, dccm_rden, dccm_wren}, 32'd0);
    tick(); #1;
    chk("t2_wren",    {31'd0, dccm_wren}, 32'd1);
    chk("t2_wr_addr", {16'd0, dccm_wr_addr}, 32'h0204);
    chk("t2_wr_data", dccm_wr_data, 32'h1122AB44);
    tick(); #1;
    chk("t2_empty",   {31'd0, sb_empty}, 32'd1);

    // Load contention: 3 stall cycles in RD, 3 in WR
    tick(); drive_st(16'h0208, 32'h00CD0000, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick(); st_valid = 1'b0; ld_rden = 1'b1; #1;
      chk("t3_rd_stall", {31'd0, dccm_rden}, 32'd0);
    end
    tick(); ld_rden = 1'b0; #1;
    chk("t3_rden_late", {31'd0, dccm_rden}, 32'd1);
    tick(); #1;
    chk("t3_merge", {31'd0, dccm_wren}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); ld_rden = 1'b1; #1;
      chk("t3_wr_stall", {31'd0, dccm_wren}, 32'd0);
    end
    tick(); ld_rden = 1'b0; #1;
    chk("t3_wren_late", {31'd0, dccm_wren}, 32'd1);
    chk("t3_wr_addr", {16'd0, dccm_wr_addr}, 32'h0208);
    chk("t3_wr_data", dccm_wr_data, 32'h11CD3344);
    tick(); #1;
    chk("t3_empty", {31'd0, sb_empty}, 32'd1);

    // Full buffer: 4 stores with port blocked, 5th held off until after first retire
    base = wlog_addr.size();
    for (int k = 0; k < 4; k++) begin
      tick(); ld_rden = 1'b1;
      drive_st(16'h0400 + 16'(4 * k), 32'hA0000000 + 32'(k), 4'hF); #1;
      chk("t4_ready_fill", {31'd0, st_ready}, 32'd1);
    end
    tick(); drive_st(16'h0410, 32'hA0000004, 4'hF); #1;
    chk("t4_full_ready", {31'd0, st_ready}, 32'd0);
    tick(); ld_rden = 1'b0; #1;
    chk("t4_ready_retire_cycle", {31'd0, st_ready}, 32'd0);
    chk("t4_first_wren", {31'd0, dccm_wren}, 32'd1);
    tick(); #1;
    chk("t4_ready_back", {31'd0, st_ready}, 32'd1);
    tick(); st_valid = 1'b0;
    wait_empty("t4_drain_done", 30);
    chk("t4_write_count", 32'(wlog_addr.size() - base), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (base + k < wlog_addr.size()) begin
        chk("t4_order_addr", {16'd0, wlog_addr[base + k]}, 32'h0400 + 32'(4 * k));
        chk("t4_order_data", wlog_data[base + k], 32'hA0000000 + 32'(k));
      end
    end

    // Forwarding table with port blocked
    s_addr[0] = 16'h0300; s_data[0] = 32'h000000AA; s_be[0] = 4'b0001;
    s_addr[1] = 16'h0300; s_data[1] = 32'h0000BB00; s_be[1] = 4'b0010;
    s_addr[2] = 16'h0300; s_data[2] = 32'h000000CC; s_be[2] = 4'b0001;
    s_addr[3] = 16'h0304; s_data[3] = 32'h12345678; s_be[3] = 4'hF;
    vecs[0] = '{2, 16'h0302, 4'h3, 32'h0000BBAA};
    vecs[1] = '{2, 16'h0300, 4'h3, 32'h0000BBAA};
    vecs[2] = '{2, 16'h0304, 4'h0, 32'h00000000};
    vecs[3] = '{4, 16'h0300, 4'h3, 32'h0000BBCC};
    vecs[4] = '{4, 16'h0303, 4'h3, 32'h0000BBCC};
    vecs[5] = '{4, 16'h0306, 4'hF, 32'h12345678};
    vecs[6] = '{4, 16'h0308, 4'h0, 32'h00000000};
    vecs[7] = '{4, 16'h1300, 4'h0, 32'h00000000};
    base   = wlog_addr.size();
    pushed = 0;
    for (int v = 0; v < 8; v++) begin
      while (pushed < vecs[v].n_st) begin
        tick(); ld_rden = 1'b1;
        drive_st(s_addr[pushed], s_data[pushed], s_be[pushed]);
        pushed++;
      end
      tick(); st_valid = 1'b0; ld_addr = vecs[v].ld_addr; #1;
      chk("t5_fwd_be",   {28'd0, fwd_byteen}, {28'd0, vecs[v].exp_be});
      chk("t5_fwd_data", fwd_data, vecs[v].exp_data);
    end
    mem_val = 32'h55667788;
    exp_w[0] = 32'h556677AA; exp_w[1] = 32'h5566BB88;
    exp_w[2] = 32'h556677CC; exp_w[3] = 32'h12345678;
    tick(); ld_rden = 1'b0; ld_addr = 16'h0300;
    wait_empty("t5_drain_done", 40);
    #1;
    chk("t5_fwd_after_drain", {28'd0, fwd_byteen}, 32'd0);
    chk("t5_write_count", 32'(wlog_addr.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < wlog_addr.size()) begin
        chk("t5_drain_addr", {16'd0, wlog_addr[base + k]}, {16'd0, s_addr[k]});
        chk("t5_drain_data", wlog_data[base + k], exp_w[k]);
      end
    end

    // Reset during MERGE with two entries queued
    mem_val = 32'h11223344;
    base = wlog_addr.size();
    tick(); drive_st(16'h0500, 32'h000000EE, 4'b0001); ld_addr = 16'h0500;
    tick(); drive_st(16'h0504, 32'h77777777, 4'hF); #1;
    chk("t6_rden", {31'd0, dccm_rden}, 32'd1);
    tick(); st_valid = 1'b0; rst = 1'b1; #1;
    chk("t6_merge_fwd", {28'd0, fwd_byteen}, 32'd1);
    tick(); rst = 1'b0; inject = 1'b1; inject_val = 32'hFFFFFFFF; #1;
    chk_reset_outputs("t6");
    tick(); inject = 1'b0;
    repeat (6) tick();
    chk("t6_no_write", 32'(wlog_addr.size() - base), 32'd0);
    chk("t6_still_empty", {31'd0, sb_empty}, 32'd1);

    chk("port_rule_violations", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
